download_packer: RTL and testbench



---
 rtl/download_packer.sv | 161 ++++++++++++++++
 tb/tb_download_packer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/download_packer.sv
// Packs 16-bit HPS download words into 64-bit masked DDR3 writes.
// A one-word skid catches the word that breaks block continuity while the old buffer drains.
module download_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        download_cs,
    input  logic        download_wr,
    input  logic [24:0] download_addr,
    input  logic [15:0] download_dout,
    output logic        download_waitReq,
    output logic        ddr_wr,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_din,
    output logic [7:0]  ddr_mask,
    output logic [7:0]  ddr_burstLength,
    input  logic        ddr_waitReq
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WRITE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_data;
    logic [7:0]  r_mask;
    logic [21:0] r_block;
    logic [15:0] r_skid_data;
    logic [1:0]  r_skid_lane;
    logic [21:0] r_skid_block;
    logic        r_skid_valid;

    logic [63:0] w_data;
    logic [7:0]  w_mask;
    logic [21:0] w_block;
    logic [15:0] w_skid_data;
    logic [1:0]  w_skid_lane;
    logic [21:0] w_skid_block;
    logic        w_skid_valid;

    logic        w_accept;
    logic [1:0]  w_in_lane;
    logic [21:0] w_in_block;
    logic        w_unused_addr0;

    assign w_accept       = download_wr & download_cs;
    assign w_in_lane      = download_addr[2:1];
    assign w_in_block     = download_addr[24:3];
    assign w_unused_addr0 = download_addr[0];

    function automatic logic [63:0] put_lane(input logic [63:0] d, input logic [1:0] lane,
                                             input logic [15:0] w);
        put_lane = (d & ~(64'hFFFF << {lane, 4'b0000})) | ({48'b0, w} << {lane, 4'b0000});
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] lane);
        lane_mask = 8'b0000_0011 << {lane, 1'b0};
    endfunction

    always_comb begin
        w_next       = r_state;
        w_data       = r_data;
        w_mask       = r_mask;
        w_block      = r_block;
        w_skid_data  = r_skid_data;
        w_skid_lane  = r_skid_lane;
        w_skid_block = r_skid_block;
        w_skid_valid = r_skid_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_data  = put_lane('0, w_in_lane, download_dout);
                    w_mask  = lane_mask(w_in_lane);
                    w_block = w_in_block;
                    w_next  = (w_in_lane == 2'd3) ? ST_WRITE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_accept) begin
                    if (w_in_block == r_block) begin
                        w_data = put_lane(r_data, w_in_lane, download_dout);
                        w_mask = r_mask | lane_mask(w_in_lane);
                        if (w_in_lane == 2'd3) begin
                            w_next = ST_WRITE;
                        end
                    end else begin
                        w_skid_data  = download_dout;
                        w_skid_lane  = w_in_lane;
                        w_skid_block = w_in_block;
                        w_skid_valid = 1'b1;
                        w_next       = ST_WRITE;
                    end
                end else if (!download_cs) begin
                    w_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!ddr_waitReq) begin
                    // An incoming word on the drain cycle with an empty skid goes straight
                    // into the fresh buffer; with a full skid it is dropped.
                    if (r_skid_valid) begin
                        w_data       = put_lane('0, r_skid_lane, r_skid_data);
                        w_mask       = lane_mask(r_skid_lane);
                        w_block      = r_skid_block;
                        w_skid_valid = 1'b0;
                        w_next       = (r_skid_lane == 2'd3) ? ST_WRITE : ST_FILL;
                    end else if (w_accept) begin
                        w_data  = put_lane('0, w_in_lane, download_dout);
                        w_mask  = lane_mask(w_in_lane);
                        w_block = w_in_block;
                        w_next  = (w_in_lane == 2'd3) ? ST_WRITE : ST_FILL;
                    end else begin
                        w_data = '0;
                        w_mask = '0;
                        w_next = ST_IDLE;
                    end
                end else if (w_accept && !r_skid_valid) begin
                    w_skid_data  = download_dout;
                    w_skid_lane  = w_in_lane;
                    w_skid_block = w_in_block;
                    w_skid_valid = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_mask       <= '0;
            r_block      <= '0;
            r_skid_data  <= '0;
            r_skid_lane  <= '0;
            r_skid_block <= '0;
            r_skid_valid <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_data       <= w_data;
            r_mask       <= w_mask;
            r_block      <= w_block;
            r_skid_data  <= w_skid_data;
            r_skid_lane  <= w_skid_lane;
            r_skid_block <= w_skid_block;
            r_skid_valid <= w_skid_valid;
        end
    end

    assign ddr_wr           = (r_state == ST_WRITE);
    assign download_waitReq = ddr_wr | r_skid_valid;
    assign ddr_addr         = BASE_ADDR + {7'b0, r_block, 3'b000};
    assign ddr_din          = r_data;
    assign ddr_mask         = r_mask;
    assign ddr_burstLength  = 8'd1;

endmodule

// File: tb/tb_download_packer.sv
// Bench for download_packer: directed scenarios plus randomized download streams
// checked against a word-grouping reference model.
module tb_download_packer;

    localparam logic [31:0] TB_BASE = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dl_cs = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [15:0] dl_dout = '0;
    logic        download_waitReq;
    logic        ddr_wr;
    logic [31:0] ddr_addr;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_mask;
    logic [7:0]  ddr_burstLength;
    logic        ddr_waitReq = 1'b0;

    download_packer #(.BASE_ADDR(TB_BASE)) dut (
        .clock            (clock),
        .reset            (reset),
        .download_cs      (dl_cs),
        .download_wr      (dl_wr),
        .download_addr    (dl_addr),
        .download_dout    (dl_dout),
        .download_waitReq (download_waitReq),
        .ddr_wr           (ddr_wr),
        .ddr_addr         (ddr_addr),
        .ddr_din          (ddr_din),
        .ddr_mask         (ddr_mask),
        .ddr_burstLength  (ddr_burstLength),
        .ddr_waitReq      (ddr_waitReq)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    logic bp_rand = 1'b0;

    // Writes seen by the DDR side; inputs change just after posedge, so the
    // negedge view is exactly what the next posedge will accept.
    logic [31:0] got_addr [0:511];
    logic [63:0] got_din  [0:511];
    logic [7:0]  got_mask [0:511];
    int got_n     = 0;
    int wr_cycles = 0;
    int rd_idx    = 0;

    always @(negedge clock) begin
        if (!reset && ddr_wr) begin
            wr_cycles <= wr_cycles + 1;
            if (!ddr_waitReq && got_n < 512) begin
                got_addr[got_n] <= ddr_addr;
                got_din[got_n]  <= ddr_din;
                got_mask[got_n] <= ddr_mask;
                got_n           <= got_n + 1;
            end
        end
    end

    typedef struct packed {
        logic [31:0] a;
        logic [63:0] d;
        logic [7:0]  m;
    } wr_t;

    wr_t exp_q[$];
    int unsigned m_block;
    logic [15:0] m_word [4];
    logic [3:0]  m_have = '0;

    task automatic model_emit();
        wr_t t;
        if (m_have != 4'b0) begin
            t.a = TB_BASE + 32'(m_block * 8);
            t.d = '0;
            t.m = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_have[i]) begin
                    t.d = t.d | (64'(m_word[i]) << (16 * i));
                    t.m = t.m | 8'(3 << (2 * i));
                end
            end
            exp_q.push_back(t);
            m_have = '0;
        end
    endtask

    task automatic model_word(input logic [24:0] a, input logic [15:0] d);
        int unsigned blk;
        int unsigned ln;
        blk = 32'(a) / 8;
        ln  = (32'(a) % 8) / 2;
        if (m_have != 4'b0 && blk != m_block) model_emit();
        m_block    = blk;
        m_word[ln] = d;
        m_have[ln] = 1'b1;
        if (ln == 3) model_emit();
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_have = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (bp_rand) ddr_waitReq = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send(input logic [24:0] a, input logic [15:0] d);
        int n;
        n = 0;
        while (download_waitReq && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_fail++;
            $error("FAIL send_wait: download_waitReq stuck high, addr %h", a);
        end
        dl_addr = a;
        dl_dout = d;
        dl_wr   = 1'b1;
        tick();
        dl_wr   = 1'b0;
        model_word(a, d);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick();
        while ((ddr_wr || download_waitReq) && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) begin
            n_checks++;
            n_fail++;
            $error("FAIL wait_idle: ddr_wr %b waitReq %b never cleared", ddr_wr, download_waitReq);
        end
        tick();
        tick();
    endtask

    task automatic end_dl();
        dl_cs = 1'b0;
        model_emit();
        wait_idle();
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                                input logic [7:0] m);
        chk({tag, "_present"}, 64'(got_n > rd_idx), 64'd1);
        if (got_n > rd_idx) begin
            chk({tag, "_addr"}, 64'(got_addr[rd_idx]), 64'(a));
            chk({tag, "_din"},  got_din[rd_idx], d);
            chk({tag, "_mask"}, 64'(got_mask[rd_idx]), 64'(m));
            rd_idx++;
        end
    endtask

    initial begin
        int c0;
        int g0;
        int nw;
        int r;
        int k;
        logic        stable;
        logic [31:0] sa;
        logic [63:0] sd;
        logic [7:0]  sm;
        logic [24:0] cur;
        wr_t         t;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_ddr_wr", 64'(ddr_wr), 64'd0);
        chk("reset_waitReq", 64'(download_waitReq), 64'd0);
        chk("reset_burst", 64'(ddr_burstLength), 64'd1);
        reset = 1'b0;
        tick();

        // Strobe with cs low must be ignored; cs low in IDLE writes nothing
        dl_addr = 25'h6;
        dl_dout = 16'h9999;
        dl_wr   = 1'b1;
        tick();
        dl_wr = 1'b0;
        repeat (4) tick();
        chk("cs_low_no_write", 64'(got_n), 64'd0);
        chk("cs_low_waitReq", 64'(download_waitReq), 64'd0);

        // Contiguous lanes 0..3
        dl_cs = 1'b1;
        c0 = wr_cycles;
        send(25'h0, 16'h1111);
        send(25'h2, 16'h2222);
        send(25'h4, 16'h3333);
        send(25'h6, 16'h4444);
        chk("contig_wr_rise", 64'(ddr_wr), 64'd1);
        chk("contig_waitReq_rise", 64'(download_waitReq), 64'd1);
        tick();
        chk("contig_wr_fall", 64'(ddr_wr), 64'd0);
        wait_idle();
        expect_write("contig", TB_BASE, 64'h4444_3333_2222_1111, 8'hFF);
        chk("contig_wr_cycles", 64'(wr_cycles - c0), 64'd1);

        // Partial flush at end of download
        send(25'h10, 16'h5555);
        send(25'h12, 16'h6666);
        end_dl();
        expect_write("partial", TB_BASE + 32'h10, 64'h0000_0000_6666_5555, 8'h0F);
        dl_cs = 1'b1;

        // Discontinuity: second word parks in skid
        send(25'h00, 16'hAAAA);
        send(25'h20, 16'hBBBB);
        chk("disc_waitReq", 64'(download_waitReq), 64'd1);
        end_dl();
        expect_write("disc_first", TB_BASE, 64'h0000_0000_0000_AAAA, 8'h03);
        expect_write("disc_second", TB_BASE + 32'h20, 64'h0000_0000_0000_BBBB, 8'h03);
        dl_cs = 1'b1;

        // Back-pressure for 20 cycles
        ddr_waitReq = 1'b1;
        send(25'h40, 16'h0101);
        send(25'h42, 16'h0202);
        send(25'h44, 16'h0303);
        send(25'h46, 16'h0404);
        sa = ddr_addr;
        sd = ddr_din;
        sm = ddr_mask;
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!ddr_wr || !download_waitReq || ddr_addr !== sa || ddr_din !== sd || ddr_mask !== sm)
                stable = 1'b0;
        end
        chk("bp_held_stable", 64'(stable), 64'd1);
        chk("bp_held_din", sd, 64'h0404_0303_0202_0101);
        ddr_waitReq = 1'b0;
        wait_idle();
        expect_write("bp", TB_BASE + 32'h40, 64'h0404_0303_0202_0101, 8'hFF);
        chk("bp_single_write", 64'(got_n), 64'(rd_idx));

        // Reset while a write is pending
        ddr_waitReq = 1'b1;
        g0 = got_n;
        send(25'h4E, 16'h7777);
        chk("rst_pre_wr", 64'(ddr_wr), 64'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_wr", 64'(ddr_wr), 64'd0);
        chk("rst_async_waitReq", 64'(download_waitReq), 64'd0);
        chk("rst_burst", 64'(ddr_burstLength), 64'd1);
        tick();
        tick();
        reset = 1'b0;
        ddr_waitReq = 1'b0;
        repeat (10) tick();
        chk("rst_no_write", 64'(got_n), 64'(g0));
        model_reset();

        // Top of the download window with a non-zero base
        send(25'h1FF_FFFE, 16'hCAFE);
        wait_idle();
        expect_write("base_top", 32'h31FF_FFF8, 64'hCAFE_0000_0000_0000, 8'hC0);
        model_reset();

        // Randomized download streams with random DDR back-pressure
        bp_rand = 1'b1;
        for (int s = 0; s < 30; s++) begin
            dl_cs = 1'b1;
            cur = 25'($urandom);
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                send(cur, 16'($urandom));
                r = $urandom_range(0, 9);
                if (r < 6)      cur = cur + 25'd2;
                else if (r < 8) cur = {cur[24:3], 2'($urandom), 1'($urandom)};
                else            cur = 25'($urandom);
            end
            end_dl();
        end
        bp_rand = 1'b0;
        ddr_waitReq = 1'b0;
        wait_idle();
        chk("rand_count", 64'(got_n - rd_idx), 64'(exp_q.size()));
        k = 0;
        while (exp_q.size() > 0 && rd_idx < got_n) begin
            t = exp_q.pop_front();
            chk($sformatf("rand%0d_addr", k), 64'(got_addr[rd_idx]), 64'(t.a));
            chk($sformatf("rand%0d_din", k), got_din[rd_idx], t.d);
            chk($sformatf("rand%0d_mask", k), 64'(got_mask[rd_idx]), 64'(t.m));
            rd_idx++;
            k++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
